// File: rtl/llc_trace_pkg.sv
// Shared types for the LLC trace command queue.
// Opcode enum, legality check and queued record layout.
package llc_trace_pkg;

    localparam int REC_ADDR_W = 32;
    localparam int REC_SEQ_W  = 16;

    typedef enum logic [3:0] {
        RD_L1D    = 4'd0,
        WR_L1D    = 4'd1,
        RD_L1I    = 4'd2,
        SNP_INV   = 4'd3,
        SNP_RD    = 4'd4,
        SNP_WR    = 4'd5,
        SNP_RWITM = 4'd6,
        CLEAR     = 4'd8,
        PRINT     = 4'd9
    } op_e;

    typedef struct packed {
        op_e                   op;
        logic [REC_ADDR_W-1:0] addr;
        logic [REC_SEQ_W-1:0]  seq;
    } rec_t;

    function automatic logic is_legal(op_e op);
        logic ok;
        ok = 1'b0;
        case (op)
            RD_L1D, WR_L1D, RD_L1I, SNP_INV,
            SNP_RD, SNP_WR, SNP_RWITM,
            CLEAR, PRINT: ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/llc_trace_cmd_queue_fifo.sv
// Synchronous FIFO with extra-MSB pointers.
// Head entry is read straight from the storage registers.
module llc_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout = mem[rd_ptr[AW-1:0]];

    // Advance pointers; wrap falls out of the extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Write the tail slot on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/llc_trace_cmd_queue.sv
// Trace record filter, sequencer and command queue.
// Drops illegal ops, tags records, decodes the head, keeps stats.
module llc_trace_cmd_queue
    import llc_trace_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int LINE_BYTES = 64,
    parameter  int SETS       = 16384,
    parameter  int DEPTH      = 8,
    parameter  int SEQ_W      = 16,
    parameter  int STAT_W     = 32,
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int IDX_W      = $clog2(SETS),
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [TAG_W-1:0]  out_tag,
    output logic [IDX_W-1:0]  out_index,
    output logic [OFF_W-1:0]  out_offset,
    output logic [SEQ_W-1:0]  out_seq,
    output logic              err_pulse,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count,
    output logic [STAT_W-1:0] inv_count
);

    localparam int REC_W = 4 + ADDR_W + SEQ_W;

    logic [SEQ_W-1:0]  seq;
    logic [REC_W-1:0]  head;
    logic [ADDR_W-1:0] head_addr;
    logic              full;
    logic              empty;
    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    op_e               head_op;

    assign in_ready  = !full;
    assign out_valid = !empty;

    assign accept = in_valid && in_ready;
    assign legal  = is_legal(op_e'(in_op));
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    llc_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({in_op, in_addr, seq}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign head_op   = op_e'(head[REC_W-1 -: 4]);
    assign head_addr = head[SEQ_W +: ADDR_W];

    assign out_op     = head[REC_W-1 -: 4];
    assign out_seq    = head[SEQ_W-1:0];
    assign out_tag    = head_addr[ADDR_W-1 -: TAG_W];
    assign out_index  = head_addr[OFF_W +: IDX_W];
    assign out_offset = head_addr[OFF_W-1:0];

    // Every accepted record, legal or not, consumes a line number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq <= '0;
        end else if (accept) begin
            seq <= seq + SEQ_W'(1);
        end
    end

    // Flag and count dropped illegal opcodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= accept && !legal;
            if (accept && !legal && err_count != '1)
                err_count <= err_count + STAT_W'(1);
        end
    end

    // Classify popped commands; a popped CLEAR wipes the op stats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count  <= '0;
            wr_count  <= '0;
            inv_count <= '0;
        end else if (pop) begin
            case (head_op)
                CLEAR: begin
                    rd_count  <= '0;
                    wr_count  <= '0;
                    inv_count <= '0;
                end
                RD_L1D, RD_L1I, SNP_RD: begin
                    if (rd_count != '1)
                        rd_count <= rd_count + STAT_W'(1);
                end
                WR_L1D, SNP_WR, SNP_RWITM: begin
                    if (wr_count != '1)
                        wr_count <= wr_count + STAT_W'(1);
                end
                SNP_INV: begin
                    if (inv_count != '1)
                        inv_count <= inv_count + STAT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_llc_trace_cmd_queue.sv
// Directed bench for the LLC trace command queue.
// Hand-computed expectations for decode, flow control and stats.
module tb_llc_trace_cmd_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [11:0] out_tag;
    logic [13:0] out_index;
    logic [5:0]  out_offset;
    logic [15:0] out_seq;
    logic        err_pulse;
    logic [31:0] err_count;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic [31:0] inv_count;

    int n_cmp;
    int n_bad;

    llc_trace_cmd_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_addr    (in_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_tag    (out_tag),
        .out_index  (out_index),
        .out_offset (out_offset),
        .out_seq    (out_seq),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .inv_count  (inv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] a);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = a;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_stats(input string tag, input int r,
                             input int w, input int v);
        chk({tag, "_rd"}, rd_count, r);
        chk({tag, "_wr"}, wr_count, w);
        chk({tag, "_inv"}, inv_count, v);
    endtask

    logic [3:0] ops4 [8];
    logic [3:0] eop;

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_addr   = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_oval", out_valid, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_errc", err_count, 0);
        chk_stats("rst", 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        chk("rst_rdy", in_ready, 1);

        // Single record decode, seq 0
        push(4'd0, 32'hDEAD_BEEF);
        chk("t1_oval", out_valid, 1);
        chk("t1_tag", out_tag, 12'hDEA);
        chk("t1_idx", out_index, 14'h36FB);
        chk("t1_off", out_offset, 6'h2F);
        chk("t1_seq", out_seq, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_empty", out_valid, 0);
        chk("t1_rd", rd_count, 1);

        // Fill to full, hold 9th, pop one, 9th enters (seq 1..9)
        for (int i = 0; i < 8; i++)
            push((i < 7) ? 4'(i) : 4'd9, 32'(i) << 6);
        chk("t2_full", in_ready, 0);
        in_valid = 1'b1;
        in_op    = 4'd8;
        in_addr  = 32'h0000_1000;
        step();
        chk("t2_held", in_ready, 0);
        chk("t2_head", out_seq, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_room", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t2_full2", in_ready, 0);
        for (int i = 1; i <= 8; i++) begin
            eop = (i < 7) ? 4'(i) : ((i == 7) ? 4'd9 : 4'd8);
            if (i == 8) chk_stats("t2_pre", 4, 3, 1);
            chk("t2_seq", out_seq, 16'(1 + i));
            chk("t2_op", out_op, eop);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk("t2_drained", out_valid, 0);
        chk_stats("t2_clr", 0, 0, 0);

        // Illegal op dropped; seq 10 burned, op1 gets seq 11
        push(4'd7, 32'h0);
        chk("t3_pulse", err_pulse, 1);
        chk("t3_errc", err_count, 1);
        chk("t3_drop", out_valid, 0);
        push(4'd1, 32'h40);
        chk("t3_pulse0", err_pulse, 0);
        chk("t3_oval", out_valid, 1);
        chk("t3_op", out_op, 1);
        chk("t3_seq", out_seq, 11);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t3_only", out_valid, 0);
        chk("t3_wr", wr_count, 1);

        // Stats: CLEAR, 3 rd, 2 wr, 1 inv, CLEAR
        ops4[0] = 4'd8; ops4[1] = 4'd0;
        ops4[2] = 4'd2; ops4[3] = 4'd4;
        ops4[4] = 4'd1; ops4[5] = 4'd5;
        ops4[6] = 4'd3; ops4[7] = 4'd8;
        for (int j = 0; j < 8; j++) push(ops4[j], 32'(j));
        chk("t4_full", in_ready, 0);
        for (int j = 0; j < 8; j++) begin
            if (j == 7) chk_stats("t4_pre", 3, 2, 1);
            chk("t4_op", out_op, ops4[j]);
            chk("t4_seq", out_seq, 16'(12 + j));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk_stats("t4_post", 0, 0, 0);
        chk("t4_errc", err_count, 1);

        // Streaming 20 records at one per cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_op   = 4'd0;
            in_addr = 32'(k) << 6;
            step();
            chk("t5_oval", out_valid, 1);
            chk("t5_seq", out_seq, 16'(20 + k));
            chk("t5_idx", out_index, 14'(k));
            chk("t5_rdy", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("t5_empty", out_valid, 0);
        chk("t5_rd", rd_count, 20);

        // Reset with records queued mid-pop
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) push(4'd2, 32'(k));
        out_ready = 1'b1;
        step();
        chk("t6_head", out_seq, 41);
        chk("t6_rd", rd_count, 21);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_oval", out_valid, 0);
        chk("t6_rd0", rd_count, 0);
        chk("t6_err0", err_count, 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        push(4'd2, 32'h0);
        chk("t6_oval1", out_valid, 1);
        chk("t6_seq0", out_seq, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
